// File: rtl/seq_mult_256_if.sv
// Start/done handshake bundle for the 256x256 sequential multiplier.
// The initiator drives start and the operands, then waits for done.
// The responder returns the product together with its done/busy status.
interface seq_mult_256_if;
    logic         start;   // request a multiply (sampled only when idle)
    logic [255:0] A;       // multiplicand, unsigned
    logic [255:0] B;       // multiplier, unsigned
    logic [511:0] P;       // registered product A*B
    logic         done;    // one-cycle pulse, P valid
    logic         busy;    // operation in flight

    modport master (output start, A, B, input P, done, busy);
    modport slave  (input start, A, B, output P, done, busy);
endinterface

// File: rtl/seq_mult_256.sv
// seq_mult_256: 256x256 -> 512 unsigned multiplier built from one Karatsuba
// step. Three 129x129 sub-products (Al*Bl, Ah*Bh, Sa*Sb) are formed one
// after another on a single digit-serial shift-add unit that consumes
// DIGIT_W multiplier bits per cycle, LSB digit first. A final combine
// cycle assembles the full product.
//
// Compile-time option: SEQ_MULT_ZERO_SKIP_EN -- when defined, an operation
// with a zero operand skips straight from LOAD to DONE with P=0.
module seq_mult_256 #(
    parameter int DIGIT_W = 16   // multiplier bits consumed per cycle: 8, 16 or 32
) (
    input logic           clk,
    input logic           rst,
    seq_mult_256_if.slave bus
);

    // Karatsuba half-sums are 129 bits; every sub-product fits in 258 bits.
    localparam int OP_W  = 129;
    localparam int N     = (OP_W + DIGIT_W - 1) / DIGIT_W;  // cycles per sub-product
    localparam int ACC_W = 2 * OP_W;                         // 258-bit accumulator
    localparam int MPL_W = N * DIGIT_W;                      // multiplier padded to whole digits
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        MUL_LO  = 3'd2,
        MUL_HI  = 3'd3,
        MUL_MID = 3'd4,
        COMBINE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Captured operands and Karatsuba half-sums.
    logic [255:0]       a_q;
    logic [255:0]       b_q;
    logic [OP_W-1:0]    sa_q;
    logic [OP_W-1:0]    sb_q;

    // Shared digit-serial shift-add unit.
    logic [ACC_W-1:0]   mcand_q;   // multiplicand, shifted left one digit per cycle
    logic [MPL_W-1:0]   mplier_q;  // multiplier, shifted right one digit per cycle
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               mul_last;
    logic               in_mul;
    logic [ACC_W-1:0]   ld_mcand;
    logic [MPL_W-1:0]   ld_mplier;

    // Sub-product results and final product.
    logic [255:0]       z0_q;      // Al*Bl
    logic [255:0]       z2_q;      // Ah*Bh
    logic [ACC_W-1:0]   z1_q;      // Sa*Sb
    logic [511:0]       mid_term;
    logic [511:0]       p_d;
    logic [511:0]       p_q;
    logic               done_q;
    logic               busy_q;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic               zero_op;
    assign zero_op = (a_q == '0) || (b_q == '0);
`endif

    assign in_mul   = (state_q == MUL_LO) || (state_q == MUL_HI) || (state_q == MUL_MID);
    assign mul_last = (cnt_q == CNT_W'(N - 1));

    // One shift-add step: add multiplicand times the current LSB digit.
    // The true sub-product is below 2^258, so the accumulator never overflows.
    assign acc_d = acc_q + mcand_q * ACC_W'(mplier_q[DIGIT_W-1:0]);

    // Middle Karatsuba term is Sa*Sb - Ah*Bh - Al*Bl, always non-negative.
    assign mid_term = 512'(z1_q) - 512'(z2_q) - 512'(z0_q);
    assign p_d      = {z2_q, 256'd0} + (mid_term << 128) + 512'(z0_q);

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from pre-edge values; blocking (=) here
    // would make results depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable encodings fall back to IDLE.
    // NOTE: state_d gets a default before the case so every path assigns
    // it; a missing assignment in combinational logic would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
`ifdef SEQ_MULT_ZERO_SKIP_EN
            LOAD:    state_d = zero_op ? DONE : MUL_LO;
`else
            LOAD:    state_d = MUL_LO;
`endif
            MUL_LO:  if (mul_last) state_d = MUL_HI;
            MUL_HI:  if (mul_last) state_d = MUL_MID;
            MUL_MID: if (mul_last) state_d = COMBINE;
            COMBINE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand selection for the next sub-product, loaded as a phase ends.
    always_comb begin
        ld_mcand  = '0;
        ld_mplier = '0;
        case (state_q)
            LOAD: begin
                ld_mcand  = ACC_W'(a_q[127:0]);
                ld_mplier = MPL_W'(b_q[127:0]);
            end
            MUL_LO: begin
                ld_mcand  = ACC_W'(a_q[255:128]);
                ld_mplier = MPL_W'(b_q[255:128]);
            end
            MUL_HI: begin
                ld_mcand  = ACC_W'(sa_q);
                ld_mplier = MPL_W'(sb_q);
            end
            default: ;
        endcase
    end

    // Shared shift-add unit: reload at phase boundaries, otherwise step one digit.
    // NOTE: the wide datapath registers are reset too, so an aborted
    // operation leaves no stale operand or partial product behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if ((state_q == LOAD) || (in_mul && mul_last)) begin
            mcand_q  <= ld_mcand;
            mplier_q <= ld_mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (in_mul) begin
            mcand_q  <= mcand_q << DIGIT_W;
            mplier_q <= mplier_q >> DIGIT_W;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Operand capture, sub-product storage, product and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            z0_q   <= '0;
            z2_q   <= '0;
            z1_q   <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            // done is registered out of DONE, so it pulses as busy drops.
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    sa_q <= {1'b0, a_q[255:128]} + {1'b0, a_q[127:0]};
                    sb_q <= {1'b0, b_q[255:128]} + {1'b0, b_q[127:0]};
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    if (zero_op) p_q <= '0;
`endif
                end
                MUL_LO:  if (mul_last) z0_q <= acc_d[255:0];
                MUL_HI:  if (mul_last) z2_q <= acc_d[255:0];
                MUL_MID: if (mul_last) z1_q <= acc_d;
                COMBINE: p_q    <= p_d;
                DONE:    busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.P    = p_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_seq_mult_256.sv
// Testbench for seq_mult_256: runs the three legal digit widths side by
// side on common stimulus and compares against an arithmetic reference.
module tb_seq_mult_256;

    localparam int NINST   = 3;
    localparam int DW[NINST] = '{8, 16, 32};
    localparam int NS[NINST] = '{17, 9, 5};
    localparam int MAX_LAT = 3 * 17 + 3;
    localparam int N_RAND  = 1000;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] a_in;
    logic [255:0] b_in;

    seq_mult_256_if if8 ();
    seq_mult_256_if if16 ();
    seq_mult_256_if if32 ();

    assign if8.start  = start;
    assign if8.A      = a_in;
    assign if8.B      = b_in;
    assign if16.start = start;
    assign if16.A     = a_in;
    assign if16.B     = b_in;
    assign if32.start = start;
    assign if32.A     = a_in;
    assign if32.B     = b_in;

    logic [511:0] p_o[NINST];
    logic         done_o[NINST];
    logic         busy_o[NINST];

    assign p_o[0] = if8.P;
    assign p_o[1] = if16.P;
    assign p_o[2] = if32.P;
    assign done_o[0] = if8.done;
    assign done_o[1] = if16.done;
    assign done_o[2] = if32.done;
    assign busy_o[0] = if8.busy;
    assign busy_o[1] = if16.busy;
    assign busy_o[2] = if32.busy;

    seq_mult_256 #(.DIGIT_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    seq_mult_256 #(.DIGIT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    seq_mult_256 #(.DIGIT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observations per instance from the last watch window.
    int           lat1[NINST];
    int           lat2[NINST];
    int           ndone[NINST];
    int           nbusy[NINST];
    logic [511:0] p1[NINST];
    logic [511:0] p2[NINST];

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] p;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected edges from the start-sampling edge to done.
    function automatic int exp_lat(input int i, input logic [255:0] a, input logic [255:0] b);
        if (ZERO_SKIP && ((a == '0) || (b == '0))) return 2;
        return 3 * NS[i] + 3;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
        case ($urandom_range(0, 7))
            0:       r[255:128] = '1;
            1:       r[127:0]   = '1;
            2:       r[255:128] = '0;
            3:       r          = '1;
            default: ;
        endcase
        return r;
    endfunction

    // Sample all instances on falling edges. Sample j shows the state after
    // rising edge S+j-1, where S is the edge that samples start; a done seen
    // at sample j therefore rose j-1 edges after S.
    task automatic watch(input int max_j, input int release_j, input int alt_j,
                         input logic [255:0] alt_a, input int alt_release_j);
        for (int i = 0; i < NINST; i++) begin
            lat1[i] = -1; lat2[i] = -1; ndone[i] = 0; nbusy[i] = 0;
            p1[i] = '0; p2[i] = '0;
        end
        for (int j = 1; j <= max_j; j++) begin
            @(negedge clk);
            for (int i = 0; i < NINST; i++) begin
                if (busy_o[i] && lat1[i] < 0) nbusy[i]++;
                if (done_o[i]) begin
                    ndone[i]++;
                    if (lat1[i] < 0) begin
                        lat1[i] = j - 1;
                        p1[i]   = p_o[i];
                    end else if (lat2[i] < 0) begin
                        lat2[i] = j - 1;
                        p2[i]   = p_o[i];
                    end
                end
            end
            if (j == release_j) start = 1'b0;
            if (j == alt_j) begin
                start = 1'b1;
                a_in  = alt_a;
            end
            if (j == alt_release_j) start = 1'b0;
        end
    endtask

    task automatic do_op(input logic [255:0] a, input logic [255:0] b,
                         input logic [511:0] exp, input string tag);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        watch(MAX_LAT + 4, 1, -1, '0, -1);
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("%s dw%0d P", tag, DW[i]), p1[i], exp);
            check($sformatf("%s dw%0d latency", tag, DW[i]), lat1[i], exp_lat(i, a, b));
            check($sformatf("%s dw%0d done pulses", tag, DW[i]), ndone[i], 1);
            check($sformatf("%s dw%0d busy cycles", tag, DW[i]), nbusy[i], exp_lat(i, a, b));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("%s dw%0d P", tag, DW[i]), p_o[i], '0);
            check($sformatf("%s dw%0d busy", tag, DW[i]), busy_o[i], 0);
            check($sformatf("%s dw%0d done", tag, DW[i]), done_o[i], 0);
        end
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        logic [511:0] rp;
        int           k;

        // Directed vectors with hand-derived products.
        tbl[0] = '{a: '1, b: '1, p: {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}};
        tbl[1] = '{a: 256'd3, b: 256'd5, p: 512'd15};
        tbl[2] = '{a: 256'd1 << 128, b: 256'd1 << 128, p: 512'd1 << 256};
        tbl[3] = '{a: 256'd0, b: 256'h1234, p: 512'd0};
        tbl[4] = '{a: 256'h1234, b: 256'd0, p: 512'd0};
        tbl[5] = '{a: 256'd1, b: '1, p: {256'd0, {256{1'b1}}}};
        tbl[6] = '{a: 256'd1 << 255, b: 256'd2, p: 512'd1 << 256};
        tbl[7] = '{a: {128'd0, {128{1'b1}}}, b: '1,
                   p: ((512'd1 << 384) - (512'd1 << 256)) - (512'd1 << 128) + 512'd1};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("post-reset idle");

        for (int v = 0; v < 8; v++) begin
            do_op(tbl[v].a, tbl[v].b, tbl[v].p, $sformatf("vec%0d", v));
        end

        // start re-asserted with a new A while busy: ignored, 7*9 stands.
        @(negedge clk);
        a_in  = 256'd7;
        b_in  = 256'd9;
        start = 1'b1;
        watch(MAX_LAT + 6, 1, 5, 256'hFF, 10);
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("busy-start dw%0d P", DW[i]), p1[i], 512'd63);
            check($sformatf("busy-start dw%0d latency", DW[i]), lat1[i], 3 * NS[i] + 3);
            check($sformatf("busy-start dw%0d done pulses", DW[i]), ndone[i], 1);
        end

        // start held high: the next operation launches from the first IDLE cycle.
        @(negedge clk);
        a_in  = 256'd3;
        b_in  = 256'd5;
        start = 1'b1;
        watch(2 * MAX_LAT + 4, -1, -1, '0, -1);
        start = 1'b0;
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("hold dw%0d first done", DW[i]), lat1[i], 3 * NS[i] + 3);
            check($sformatf("hold dw%0d second done", DW[i]), lat2[i], 2 * (3 * NS[i] + 3) + 1);
            check($sformatf("hold dw%0d P1", DW[i]), p1[i], 512'd15);
            check($sformatf("hold dw%0d P2", DW[i]), p2[i], 512'd15);
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_o[0] && !busy_o[1] && !busy_o[2]) break;
        end
        check("hold drain", (k < 200), 1);
        @(negedge clk);

        // Reset mid-operation: immediate clear, no done, then a clean restart.
        @(negedge clk);
        a_in  = 256'd7;
        b_in  = 256'd9;
        start = 1'b1;
        watch(12, 1, -1, '0, -1);
        #3 rst = 1'b1;
        #1 check_idle_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        watch(MAX_LAT + 4, 1, -1, '0, -1);
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("abort dw%0d done pulses", DW[i]), ndone[i], 0);
            check($sformatf("abort dw%0d P", DW[i]), p_o[i], '0);
        end
        do_op(256'd2, 256'd2, 512'd4, "post-abort");

        // Random sweep against plain 512-bit arithmetic.
        for (int v = 0; v < N_RAND; v++) begin
            ra = rand256();
            rb = rand256();
            rp = 512'(ra) * 512'(rb);
            do_op(ra, rb, rp, $sformatf("rand%0d", v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_256.md
SEQ_MULT_256 -- requirements
Module: seq_mult_256

Interface
REQ-001 SHALL have parameter DIGIT_W, default 16: multiplier digit width in bits per cycle; legal values 8, 16, 32.
REQ-002 SHALL define derived constant N = ceil(129/DIGIT_W), the cycles per sub-product: 17, 9 or 5.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-006 SHALL have port A, input, 256 bits: multiplicand, unsigned.
REQ-007 SHALL have port B, input, 256 bits: multiplier, unsigned.
REQ-008 SHALL have port P, output, 512 bits: product A*B, registered.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, P valid.
REQ-010 SHALL have port busy, output, 1 bit: high from start acceptance until done.

Function
REQ-011 SHALL act as the responder of the start/done handshake; the initiator pulses start and waits for done.
REQ-012 SHALL use states IDLE, LOAD, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE.
REQ-013 IDLE with start=1 SHALL capture A and B into internal registers, set busy=1 and go to LOAD.
REQ-014 LOAD (1 cycle) SHALL form the 129-bit sums Sa=A[255:128]+A[127:0] and Sb=B[255:128]+B[127:0].
REQ-015 MUL_LO, MUL_HI and MUL_MID SHALL each last exactly N cycles and compute Z0=Al*Bl, Z2=Ah*Bh and Z1=Sa*Sb respectively.
REQ-016 Each sub-product SHALL be computed by one shared digit-serial shift-add unit that consumes DIGIT_W bits of the second operand per cycle, LSB digit first.
REQ-017 The accumulator SHALL be 258 bits wide and lose no carry.
REQ-018 COMBINE (1 cycle) SHALL compute P = Z2<<256 + (Z1-Z2-Z0)<<128 + Z0 at full 512-bit precision; the middle term is never negative.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-020 done SHALL rise exactly 3N+3 clock edges after the start-sampling edge (30 for DIGIT_W=16).
REQ-021 P SHALL hold its value from done until COMBINE of the next operation.
REQ-022 start while busy=1 SHALL be ignored, and so SHALL changes on A or B after capture.
REQ-023 start held high continuously SHALL launch a new operation in the cycle after DONE, i.e. the first cycle back in IDLE.
REQ-024 Any undefined state encoding SHALL go to IDLE.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, P=0, done=0, busy=0 and clear all operand and accumulator registers, independent of clk.
REQ-026 rst during any state SHALL abort the operation with no done pulse.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-028 The macro SEQ_MULT_ZERO_SKIP_EN SHALL be the only compile-time option.
REQ-029 With SEQ_MULT_ZERO_SKIP_EN defined, an operation whose captured A==0 or B==0 SHALL go LOAD->DONE with P=0, and done SHALL rise 2 edges after the start-sampling edge.
REQ-030 Without SEQ_MULT_ZERO_SKIP_EN, zero operands SHALL take the full 3N+3 latency with no zero-detect logic present.

Verification
REQ-031 A=B=2^256-1 -> P=0xFFFF...FFFE followed by 0x0000...0001 (upper 256 bits =2^256-2, lower =1), done at cycle 30.
REQ-032 A=3, B=5 -> P=15; A=2^128, B=2^128 -> P=2^256; both with busy high for cycles 1..30.
REQ-033 start at cycle 0 with A=7, B=9, then start=1 and A=0xFF at cycle 5 -> P=63 at cycle 30 and no second operation until IDLE.
REQ-034 rst pulsed at cycle 12 of an operation -> P=0, busy=0 at once, no done; a new start with A=B=2 afterwards -> P=4.
REQ-035 A=0, B=0x1234 -> P=0 with done at cycle 2 when SEQ_MULT_ZERO_SKIP_EN is defined, and at cycle 30 when it is not.
REQ-036 Random A,B sweep (>=1000 vectors) for each DIGIT_W value -> P matches the reference product and latency = 3N+3.
